spi_clk_gen: RTL and testbench
==============================

Name: spi_clk_gen

Overview:
- Serial clock generator for the SPI master.
- Sits directly upstream of the shift stage. Divides the system clock into the SPI serial clock and drives the shift stage's pos_edge/neg_edge strobe inputs.
- Stops the clock cleanly when the shift stage flags the last bit.
- Programmable divider, with clock polarity captured at transfer start.

Parameters:
DIVIDER_LEN, 16, width of the divider value and of the internal half-period counter.

Ports:
i_clk  input  1  system clock
i_rst_n  input  1  asynchronous active-low reset
i_go  input  1  start request, single-cycle pulse from control registers
i_enable  input  1  transfer-in-progress qualifier (shift stage tip)
i_last_clk  input  1  shift stage last-bit flag
i_divider  input  DIVIDER_LEN  half-period = i_divider+1 system clocks
i_cpol  input  1  serial clock idle level
o_clk_out  output  1  serial clock to pad, registered
o_pos_edge  output  1  one-cycle strobe, internal rising edge
o_neg_edge  output  1  one-cycle strobe, internal falling edge
o_busy  output  1  high while state is RUN

Behaviour:
- Reset is asynchronous and active-low. Clock is i_clk.
- Reset values: o_clk_out=0, o_pos_edge=0, o_neg_edge=0, o_busy=0, state=IDLE, counter=0, internal phase=0, latched divider=0, latched cpol=0.
- Internal phase ph is the unpolarised clock. o_clk_out = ph XOR latched_cpol, registered.
- o_pos_edge and o_neg_edge always refer to ph, independent of polarity.
- All outputs are registered. A strobe is high in the same cycle that o_clk_out shows the new level.
- Strobes are never both high. Each strobe lasts exactly one cycle.
- IDLE state:
  - ph=0 and strobes=0.
  - Each cycle, latched_cpol<=i_cpol, so o_clk_out follows i_cpol with 1-cycle latency.
  - If i_go=1, then latched_div<=i_divider, latched_cpol<=i_cpol, counter<=i_divider, o_busy<=1, and next state is RUN.
- RUN state:
  - Latched values are frozen. Changes on i_divider and i_cpol are ignored until the next IDLE.
  - i_go is ignored.
  - If counter!=0: counter decrements by 1 and there are no strobes.
  - If counter==0 and ph=0 and i_last_clk=0: ph<=1, o_pos_edge<=1, counter<=latched_div.
  - If counter==0 and ph=1: ph<=0, o_neg_edge<=1, counter<=latched_div. i_last_clk is ignored at this point.
  - If counter==0 and ph=0 and i_last_clk=1 (terminal pulse): o_pos_edge<=1 with no ph toggle. Then o_busy<=0 and next state is IDLE. This strobe lets the shift stage drop tip.
  - If i_enable=0 while in RUN, it takes priority over every rule above: next cycle ph=0, no strobes, o_busy=0, IDLE.
- Timing:
  - i_go is sampled at edge E0.
  - The first ph rise is visible after edge E(latched_div+1).
  - Each half-period is latched_div+1 cycles, so the full period is 2*(latched_div+1).
  - With i_divider=0, ph toggles every cycle and strobes alternate every cycle.
  - Counter arithmetic is unsigned DIVIDER_LEN wide. i_divider at its maximum value must not overflow; the counter never loads anything above latched_div.
- Reset mid-transfer returns immediately to the reset values. The next transfer needs a new i_go.
- i_go and i_enable falling in the same cycle while in IDLE: start is taken. The RUN abort applies in the following cycle if i_enable is still 0.

Test Plan:
- i_divider=1, i_cpol=0, go at E0, i_last_clk raised after the 8th o_pos_edge:
  - first rise after E2, period 4 cycles;
  - 8 rises and 8 falls on o_clk_out;
  - 9 o_pos_edge strobes (the last with no toggle);
  - o_busy high for exactly 34 cycles;
  - o_clk_out ends at 0.
- i_divider=0, i_cpol=0, 4-bit transfer: o_clk_out toggles every cycle, strobes alternate pos/neg every cycle, terminal pos strobe, then IDLE.
- i_cpol=1, i_divider=2: idle o_clk_out=1. First transition is 1->0 after E3 together with o_pos_edge. Returns to 1 at the end of the transfer.
- i_divider changed from 3 to 0 mid-RUN, and i_go pulsed mid-RUN: period stays 8 cycles and no restart occurs.
- i_enable dropped mid-RUN while ph=1: next cycle o_clk_out=i_cpol level, no strobe, o_busy=0. A following i_go starts cleanly.
- i_rst_n asserted mid-RUN with i_divider=0xFFFF: all outputs 0 asynchronously. After release the block stays IDLE until i_go.

Source files
------------

// File: rtl/spi_clk_gen.sv
// SPI serial clock generator: divides i_clk into the serial clock and
// emits registered pos/neg strobes for the shift stage.
module spi_clk_gen #(
  parameter int DIVIDER_LEN = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_go,
  input  logic                   i_enable,
  input  logic                   i_last_clk,
  input  logic [DIVIDER_LEN-1:0] i_divider,
  input  logic                   i_cpol,
  output logic                   o_clk_out,
  output logic                   o_pos_edge,
  output logic                   o_neg_edge,
  output logic                   o_busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [DIVIDER_LEN-1:0] cnt_q, cnt_d;
  logic [DIVIDER_LEN-1:0] div_q, div_d;
  logic                   ph_q, ph_d;
  logic                   cpol_q, cpol_d;
  logic                   clk_q, clk_d;
  logic                   pos_q, pos_d;
  logic                   neg_q, neg_d;
  logic                   busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    ph_d    = ph_q;
    cpol_d  = cpol_q;
    pos_d   = 1'b0;
    neg_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        ph_d   = 1'b0;
        cpol_d = i_cpol;
        if (i_go) begin
          div_d   = i_divider;
          cnt_d   = i_divider;
          state_d = RUN;
        end
      end
      RUN: begin
        if (!i_enable) begin
          ph_d    = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DIVIDER_LEN'(1);
        end else if (ph_q) begin
          ph_d  = 1'b0;
          neg_d = 1'b1;
          cnt_d = div_q;
        end else if (!i_last_clk) begin
          ph_d  = 1'b1;
          pos_d = 1'b1;
          cnt_d = div_q;
        end else begin
          // terminal strobe: lets the shift stage drop tip, no toggle
          pos_d   = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
    busy_d = (state_d == RUN);
    clk_d  = ph_d ^ cpol_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      ph_q    <= 1'b0;
      cpol_q  <= 1'b0;
      clk_q   <= 1'b0;
      pos_q   <= 1'b0;
      neg_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      ph_q    <= ph_d;
      cpol_q  <= cpol_d;
      clk_q   <= clk_d;
      pos_q   <= pos_d;
      neg_q   <= neg_d;
      busy_q  <= busy_d;
    end
  end

  assign o_clk_out  = clk_q;
  assign o_pos_edge = pos_q;
  assign o_neg_edge = neg_q;
  assign o_busy     = busy_q;

endmodule

// File: tb/tb_spi_clk_gen.sv
// Scoreboard bench for spi_clk_gen: expected strobes are queued by the
// stimulus and popped by an independent monitor.
module tb_spi_clk_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        go = 1'b0;
  logic        en = 1'b1;
  logic        last = 1'b0;
  logic [15:0] div = '0;
  logic        cpol = 1'b0;
  logic        clk_out, pos_e, neg_e, busy;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int cyc;
    bit pos;
    bit lvl;
  } exp_t;

  exp_t sbq[$];

  spi_clk_gen #(.DIVIDER_LEN(16)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_go       (go),
    .i_enable   (en),
    .i_last_clk (last),
    .i_divider  (div),
    .i_cpol     (cpol),
    .o_clk_out  (clk_out),
    .o_pos_edge (pos_e),
    .o_neg_edge (neg_e),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d cyc=%0d",
               nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // monitor: every strobe must match the head of the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (pos_e || neg_e)) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", cyc, -1);
        end else begin
          e = sbq.pop_front();
          chk("strobe_cyc", cyc, e.cyc);
          chk("strobe_pos", int'(pos_e), int'(e.pos));
          chk("strobe_neg", int'(neg_e), int'(!e.pos));
          chk("strobe_lvl", int'(clk_out), int'(e.lvl));
        end
      end
    end
  end

  task automatic run_xfer(input int d, input bit cp,
                          input int nb, input bit mess);
    int h, c0, last_at, nbusy, g;
    h = d + 1;
    div = 16'(d);
    cpol = cp;
    tick();
    chk("idle_lvl", int'(clk_out), int'(cp));
    c0 = cyc + 1;
    for (int j = 0; j < nb; j++) begin
      sbq.push_back('{c0 + h + 2*h*j, 1'b1, !cp});
      sbq.push_back('{c0 + 2*h + 2*h*j, 1'b0, cp});
    end
    sbq.push_back('{c0 + 2*h*nb + h, 1'b1, cp});
    go = 1'b1;
    tick();
    go = 1'b0;
    last_at = h + 2*h*(nb-1);
    nbusy = 0;
    for (int i = 0; i < last_at; i++) begin
      nbusy += int'(busy);
      if (mess && i == 5) begin
        div = 16'd0;
        cpol = !cp;
        go = 1'b1;
      end
      if (mess && i == 6) go = 1'b0;
      tick();
    end
    last = 1'b1;
    g = 0;
    while (busy && g < 1000) begin
      nbusy++;
      g++;
      tick();
    end
    last = 1'b0;
    chk("busy_cycles", nbusy, 2*h*nb + h);
    chk("end_lvl", int'(clk_out), int'(cp));
    cpol = cp;
  endtask

  initial begin
    int c0, n;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_pos", int'(pos_e), 0);
    chk("rst_neg", int'(neg_e), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    run_xfer(1, 1'b0, 8, 1'b0);
    run_xfer(0, 1'b0, 4, 1'b0);
    run_xfer(2, 1'b1, 3, 1'b0);
    run_xfer(3, 1'b0, 3, 1'b1);

    // abort while ph=1 with cpol=1
    div = 16'd1;
    cpol = 1'b1;
    tick();
    c0 = cyc + 1;
    sbq.push_back('{c0 + 2, 1'b1, 1'b0});
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    tick();
    chk("abort_pre_lvl", int'(clk_out), 0);
    en = 1'b0;
    tick();
    chk("abort_busy", int'(busy), 0);
    chk("abort_lvl", int'(clk_out), 1);
    chk("abort_pos", int'(pos_e), 0);
    chk("abort_neg", int'(neg_e), 0);
    en = 1'b1;
    run_xfer(0, 1'b0, 2, 1'b0);

    // asynchronous reset mid-transfer at max divider
    div = 16'hFFFF;
    cpol = 1'b1;
    tick();
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (10) tick();
    chk("pre_rst_busy", int'(busy), 1);
    chk("pre_rst_lvl", int'(clk_out), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk", int'(clk_out), 0);
    chk("arst_pos", int'(pos_e), 0);
    chk("arst_neg", int'(neg_e), 0);
    chk("arst_busy", int'(busy), 0);
    tick();
    tick();
    rst_n = 1'b1;
    n = 0;
    repeat (20) begin
      tick();
      if (busy) n++;
    end
    chk("post_rst_idle", n, 0);
    chk("post_rst_lvl", int'(clk_out), 1);
    run_xfer(2, 1'b0, 2, 1'b0);

    repeat (4) tick();
    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
